// File: rtl/aq_fdsu_expnt_pipe_if.sv
// aq_fdsu_expnt_pipe_if: issue/retire handshake bundle for the FDSU exponent/flag sideband pipe
//   in_vld/in_expnt/in_flags  : issue request and payload, driven by the issuer (master)
//   in_rdy                    : pipe can accept an issue this cycle
//   out_vld/out_expnt/out_flags : oldest entry presented by the pipe (slave)
//   out_rdy                   : consumer accepts the presented entry
interface aq_fdsu_expnt_pipe_if #(
    parameter int EXPW  = 13,
    parameter int FLAGW = 12
);
    logic             in_vld;
    logic             in_rdy;
    logic [EXPW-1:0]  in_expnt;
    logic [FLAGW-1:0] in_flags;
    logic             out_vld;
    logic             out_rdy;
    logic [EXPW-1:0]  out_expnt;
    logic [FLAGW-1:0] out_flags;
    modport master (
        output in_vld, in_expnt, in_flags, out_rdy,
        input  in_rdy, out_vld, out_expnt, out_flags
    );
    modport slave (
        input  in_vld, in_expnt, in_flags, out_rdy,
        output in_rdy, out_vld, out_expnt, out_flags
    );
endinterface

// File: rtl/aq_fdsu_expnt_pipe.sv
// aq_fdsu_expnt_pipe: elastic multi-stage exponent/flag sideband pipeline for the FDSU divide/sqrt unit
//   forever_cpuclk, cpurst_b : clock, asynchronous active-low reset
//   flush                    : kill every in-flight entry next edge
//   io (slave)               : issue handshake into R[1], retire handshake out of R[STAGES]
//   stg_vld/stg_expnt/stg_flags : per-stage register contents, R[i] in slice i-1
//   upd_vld/upd_expnt        : exponent replacement applied on the R[i]->R[i+1] move
//   flag_set/flag_clr        : flag edits applied on the R[i]->R[i+1] move, set wins
//   busy                     : any stage holds a valid entry
module aq_fdsu_expnt_pipe #(
    parameter int EXPW   = 13,
    parameter int STAGES = 4,
    parameter int FLAGW  = 12
) (
    input  logic                        forever_cpuclk,
    input  logic                        cpurst_b,
    input  logic                        flush,
    aq_fdsu_expnt_pipe_if.slave         io,
    output logic [STAGES*EXPW-1:0]      stg_expnt,
    output logic [STAGES*FLAGW-1:0]     stg_flags,
    output logic [STAGES-1:0]           stg_vld,
    input  logic [STAGES-2:0]           upd_vld,
    input  logic [(STAGES-1)*EXPW-1:0]  upd_expnt,
    input  logic [(STAGES-1)*FLAGW-1:0] flag_set,
    input  logic [(STAGES-1)*FLAGW-1:0] flag_clr,
    output logic                        busy
);
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] mv;
    logic [STAGES-1:0] vld_nxt;
    logic [EXPW-1:0]   expnt [STAGES];
    logic [FLAGW-1:0]  flags [STAGES];
    logic              issue;
    // Readiness ripples from the consumer back toward the issue port, so a
    // full pipe that pops can accept a new entry in the same cycle.
    always_comb begin
        logic room;
        mv = '0;
        room = io.out_rdy;
        for (int k = STAGES - 1; k >= 0; k--) begin
            mv[k] = vld[k] & room;
            room  = !vld[k] | mv[k];
        end
        io.in_rdy = !flush & room;
        issue = io.in_vld & !flush & room;
    end
    always_comb begin
        vld_nxt = vld & ~mv;
        vld_nxt[0] = vld_nxt[0] | issue;
        for (int k = 1; k < STAGES; k++)
            vld_nxt[k] = vld_nxt[k] | mv[k-1];
    end
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                expnt[k] <= '0;
                flags[k] <= '0;
            end
        end else begin
            vld <= flush ? '0 : vld_nxt;
            if (issue) begin
                expnt[0] <= io.in_expnt;
                flags[0] <= io.in_flags;
            end
            for (int k = 1; k < STAGES; k++)
                if (mv[k-1]) begin
                    expnt[k] <= upd_vld[k-1] ? upd_expnt[(k-1)*EXPW +: EXPW] : expnt[k-1];
                    flags[k] <= (flags[k-1] & ~flag_clr[(k-1)*FLAGW +: FLAGW]) | flag_set[(k-1)*FLAGW +: FLAGW];
                end
        end
    end
    always_comb begin
        stg_expnt = '0;
        stg_flags = '0;
        for (int k = 0; k < STAGES; k++) begin
            stg_expnt[k*EXPW +: EXPW]   = expnt[k];
            stg_flags[k*FLAGW +: FLAGW] = flags[k];
        end
    end
    assign stg_vld      = vld;
    assign busy         = |vld;
    assign io.out_vld   = vld[STAGES-1];
    assign io.out_expnt = expnt[STAGES-1];
    assign io.out_flags = flags[STAGES-1];
endmodule

// File: tb/tb_aq_fdsu_expnt_pipe.sv
// tb_aq_fdsu_expnt_pipe: directed self-checking bench for the exponent/flag sideband pipe
module tb_aq_fdsu_expnt_pipe;
    localparam int EXPW   = 13;
    localparam int STAGES = 4;
    localparam int FLAGW  = 12;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        flush = 1'b0;
    logic [STAGES*EXPW-1:0]      stg_expnt;
    logic [STAGES*FLAGW-1:0]     stg_flags;
    logic [STAGES-1:0]           stg_vld;
    logic [STAGES-2:0]           upd_vld = '0;
    logic [(STAGES-1)*EXPW-1:0]  upd_expnt = '0;
    logic [(STAGES-1)*FLAGW-1:0] flag_set = '0;
    logic [(STAGES-1)*FLAGW-1:0] flag_clr = '0;
    logic                        busy;

    int checks = 0;
    int passed = 0;

    aq_fdsu_expnt_pipe_if #(.EXPW(EXPW), .FLAGW(FLAGW)) io ();

    aq_fdsu_expnt_pipe #(.EXPW(EXPW), .STAGES(STAGES), .FLAGW(FLAGW)) dut (
        .forever_cpuclk(clk),
        .cpurst_b(rst_n),
        .flush(flush),
        .io(io),
        .stg_expnt(stg_expnt),
        .stg_flags(stg_flags),
        .stg_vld(stg_vld),
        .upd_vld(upd_vld),
        .upd_expnt(upd_expnt),
        .flag_set(flag_set),
        .flag_clr(flag_clr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: slot contents only; an entry advances when any slot
    // ahead of it is free or the consumer is taking the head.
    logic             m_vld [STAGES];
    logic [EXPW-1:0]  m_e   [STAGES];
    logic [FLAGW-1:0] m_f   [STAGES];
    logic [EXPW-1:0]  m_pops[$];
    logic [EXPW-1:0]  d_pops[$];

    function automatic bit m_room(input int from);
        if (io.out_rdy) return 1'b1;
        for (int j = from; j < STAGES; j++)
            if (!m_vld[j]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                m_vld[k] = 1'b0;
                m_e[k]   = '0;
                m_f[k]   = '0;
            end
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) m_vld[k] = 1'b0;
        end else begin : adv_blk
            bit adv [STAGES];
            bit take;
            take = io.in_vld && m_room(0);
            for (int k = 0; k < STAGES; k++) adv[k] = m_vld[k] && m_room(k + 1);
            if (adv[STAGES-1]) m_pops.push_back(m_e[STAGES-1]);
            for (int k = STAGES - 1; k > 0; k--) begin
                if (adv[k-1]) begin
                    m_vld[k] = 1'b1;
                    m_e[k] = upd_vld[k-1] ? upd_expnt[(k-1)*EXPW +: EXPW] : m_e[k-1];
                    m_f[k] = (m_f[k-1] & ~flag_clr[(k-1)*FLAGW +: FLAGW]) | flag_set[(k-1)*FLAGW +: FLAGW];
                end else if (adv[k]) m_vld[k] = 1'b0;
            end
            if (take) begin
                m_vld[0] = 1'b1;
                m_e[0]   = io.in_expnt;
                m_f[0]   = io.in_flags;
            end else if (adv[0]) m_vld[0] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin : cmp_blk
            logic [STAGES-1:0] ev;
            for (int k = 0; k < STAGES; k++) ev[k] = m_vld[k];
            chk("in_rdy", io.in_rdy, !flush && m_room(0));
            chk("stg_vld", stg_vld, ev);
            chk("busy", busy, |ev);
            chk("out_vld", io.out_vld, ev[STAGES-1]);
            for (int k = 0; k < STAGES; k++)
                if (ev[k]) begin
                    chk($sformatf("stg_expnt[%0d]", k), stg_expnt[k*EXPW +: EXPW], m_e[k]);
                    chk($sformatf("stg_flags[%0d]", k), stg_flags[k*FLAGW +: FLAGW], m_f[k]);
                end
            if (ev[STAGES-1]) begin
                chk("out_expnt", io.out_expnt, m_e[STAGES-1]);
                chk("out_flags", io.out_flags, m_f[STAGES-1]);
            end
            if (io.out_vld && io.out_rdy && !flush) d_pops.push_back(io.out_expnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        io.in_vld = 1'b0;
        io.in_expnt = '0;
        io.in_flags = '0;
        upd_vld = '0;
        upd_expnt = '0;
        flag_set = '0;
        flag_clr = '0;
        flush = 1'b0;
    endtask

    task automatic fill4(input int base);
        io.out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io.in_vld = 1'b1;
            io.in_expnt = EXPW'(base + i);
            step();
        end
        io.in_vld = 1'b0;
    endtask

    initial begin
        int n;
        int lat;
        logic acc;
        idle_inputs();
        io.out_rdy = 1'b1;
        #12;
        chk("rst out_vld", io.out_vld, 0);
        chk("rst out_expnt", io.out_expnt, 0);
        chk("rst out_flags", io.out_flags, 0);
        chk("rst stg_vld", stg_vld, 0);
        chk("rst stg_expnt", stg_expnt, 0);
        chk("rst stg_flags", stg_flags, 0);
        chk("rst busy", busy, 0);
        chk("rst in_rdy", io.in_rdy, 1);
        rst_n = 1'b1;
        step();

        // single op with an exponent replace on R2->R3 and a flag set on R3->R4
        io.in_vld = 1'b1;
        io.in_expnt = 13'h03FF;
        io.in_flags = 12'h000;
        upd_vld = 3'b010;
        upd_expnt = {13'h0000, 13'h0400, 13'h0000};
        flag_set = {12'h004, 12'h000, 12'h000};
        step();
        io.in_vld = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("single out_vld", io.out_vld, 1);
        chk("single out_expnt", io.out_expnt, 13'h0400);
        chk("single out_flags", io.out_flags, 12'h004);
        step();
        @(negedge clk);
        chk("single busy after", busy, 0);
        step();
        idle_inputs();

        // set wins over clear on the R1->R2 move
        io.in_vld = 1'b1;
        io.in_expnt = 13'h0005;
        io.in_flags = 12'h0F0;
        flag_clr = {24'h0, 12'h030};
        flag_set = {24'h0, 12'h010};
        step();
        io.in_vld = 1'b0;
        step();
        @(negedge clk);
        chk("flag prio R2", stg_flags[FLAGW +: FLAGW], 12'h0D0);
        step();
        idle_inputs();
        repeat (5) step();

        // back-pressure: six back-to-back issues against a stalled consumer
        d_pops.delete();
        m_pops.delete();
        io.out_rdy = 1'b0;
        io.in_vld = 1'b1;
        n = 1;
        for (int c = 0; c < 8; c++) begin
            io.in_expnt = EXPW'(n);
            @(negedge clk);
            acc = io.in_rdy;
            step();
            if (acc) n++;
        end
        chk("bp accepted", 64'(n - 1), 4);
        @(negedge clk);
        chk("bp in_rdy full", io.in_rdy, 0);
        step();
        io.out_rdy = 1'b1;
        for (int c = 0; c < 20 && n <= 6; c++) begin
            io.in_expnt = EXPW'(n);
            @(negedge clk);
            acc = io.in_rdy;
            step();
            if (acc) n++;
        end
        io.in_vld = 1'b0;
        repeat (8) step();
        chk("bp pop count", 64'(d_pops.size()), 6);
        chk("bp model pop count", 64'(m_pops.size()), 6);
        for (int i = 0; i < 6 && i < d_pops.size(); i++)
            chk($sformatf("bp pop %0d", i), d_pops[i], 64'(i + 1));

        // full pipe: pop and issue in the same cycle
        d_pops.delete();
        fill4(17);
        io.in_vld = 1'b1;
        io.in_expnt = 13'h0015;
        io.out_rdy = 1'b1;
        @(negedge clk);
        chk("full pop in_rdy", io.in_rdy, 1);
        chk("full pop head", io.out_expnt, 13'h0011);
        step();
        io.in_vld = 1'b0;
        io.out_rdy = 1'b0;
        @(negedge clk);
        chk("full pop R1", stg_expnt[0 +: EXPW], 13'h0015);
        chk("full pop new head", io.out_expnt, 13'h0012);
        chk("full pop stg_vld", stg_vld, 4'hF);
        step();
        io.out_rdy = 1'b1;
        repeat (6) step();
        chk("full pop count", 64'(d_pops.size()), 5);
        for (int i = 0; i < 5 && i < d_pops.size(); i++)
            chk($sformatf("full pop order %0d", i), d_pops[i], 64'(17 + i));

        // flush with three in flight plus a concurrent issue
        io.out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            io.in_vld = 1'b1;
            io.in_expnt = EXPW'(33 + i);
            step();
        end
        d_pops.delete();
        flush = 1'b1;
        io.in_expnt = 13'h0024;
        io.out_rdy = 1'b1;
        @(negedge clk);
        chk("flush in_rdy", io.in_rdy, 0);
        step();
        flush = 1'b0;
        io.in_vld = 1'b0;
        @(negedge clk);
        chk("flush stg_vld", stg_vld, 0);
        chk("flush busy", busy, 0);
        repeat (6) step();
        chk("flush no pops", 64'(d_pops.size()), 0);
        io.in_vld = 1'b1;
        io.in_expnt = 13'h1FF0;
        step();
        io.in_vld = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("neg out_vld", io.out_vld, 1);
        chk("neg out_expnt", io.out_expnt, 13'h1FF0);
        step();
        step();

        // asynchronous reset while full
        fill4(49);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst out_vld", io.out_vld, 0);
        chk("arst in_rdy", io.in_rdy, 1);
        chk("arst busy", busy, 0);
        chk("arst stg_vld", stg_vld, 0);
        chk("arst out_expnt", io.out_expnt, 0);
        #1;
        rst_n = 1'b1;
        io.out_rdy = 1'b1;
        io.in_vld = 1'b1;
        io.in_expnt = 13'h0077;
        step();
        io.in_vld = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (io.out_vld) begin
                lat = c;
                break;
            end
        end
        chk("arst latency", 64'(lat), 4);
        chk("arst out_expnt after", io.out_expnt, 13'h0077);
        step();
        step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
